and3_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 3-input AND evaluation unit among three requesters. Each requester presents a 3-bit operand vector and holds a request. The block grants one requester at a time, latches its operands, evaluates them through an internal `and_3in`-style datapath, and returns a registered result with a one-cycle done pulse. It sits between the lab's requester logic and the shared gate resource.

---
 rtl/and3_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_and3_rr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/and3_rr_arbiter.sv
// and3_rr_arbiter: round-robin arbiter that shares one 3-input AND evaluation
// unit among three requesters.
// The sequence IDLE -> GRANT -> RESULT runs once per granted operation.
// Optional feature macro: AND3_ARB_CNT_EN
//   defined     : eval_cnt counts completed evaluations and wraps.
//   not defined : there are no counter flops and eval_cnt is tied to 0.
module and3_rr_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [2:0]       opnd0,
  input  logic [2:0]       opnd1,
  input  logic [2:0]       opnd2,
  output logic [2:0]       gnt,
  output logic [2:0]       done,
  output logic             o,
  output logic             busy,
  output logic [CNT_W-1:0] eval_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;      // most recent winner
  logic [1:0] winner_q, winner_d;  // requester owning the current operation
  logic [2:0] opnd_q, opnd_d;      // operands latched at grant
  logic       o_q, o_d;

  logic [1:0] last_eff;
  logic [1:0] prio1, prio2;
  logic [1:0] win_idx;
  logic [2:0] win_opnd;

  // Adds two indices modulo 3; the inputs are always in the range 0..2.
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Pick the first requester in the order last+1, last+2, last.
  always_comb begin
    // An illegal pointer value of 3 is treated as 2.
    last_eff = (last_q == 2'd3) ? 2'd2 : last_q;
    prio1    = mod3_add(last_eff, 2'd1);
    prio2    = mod3_add(last_eff, 2'd2);
    if (req[prio1])      win_idx = prio1;
    else if (req[prio2]) win_idx = prio2;
    else                 win_idx = last_eff;
    case (win_idx)
      2'd0:    win_opnd = opnd0;
      2'd1:    win_opnd = opnd1;
      default: win_opnd = opnd2;
    endcase
  end

  // Next-state and datapath-update logic for the sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    last_d   = last_q;
    winner_d = winner_q;
    opnd_d   = opnd_q;
    o_d      = o_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = GRANT;
          last_d   = win_idx;
          winner_d = win_idx;
          opnd_d   = win_opnd;
        end
      end
      GRANT: begin
        state_d = RESULT;
        o_d     = &opnd_q;
      end
      RESULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before this edge, whatever the statement order.
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 2'd2;
      winner_q <= 2'd0;
      opnd_q   <= 3'b000;
      o_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      opnd_q   <= opnd_d;
      o_q      <= o_d;
    end
  end

  assign gnt  = (state_q == GRANT)  ? (3'b001 << winner_q) : 3'b000;
  assign done = (state_q == RESULT) ? (3'b001 << winner_q) : 3'b000;
  assign o    = o_q;
  assign busy = (state_q != IDLE);

`ifdef AND3_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count each completed evaluation on the RESULT -> IDLE edge; wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RESULT) cnt_d = cnt_q + CNT_W'(1);
  end

  // Evaluation counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign eval_cnt = cnt_q;
`else
  assign eval_cnt = '0;
`endif

endmodule

// File: tb/tb_and3_rr_arbiter.sv
// Self-checking bench for and3_rr_arbiter. Inputs are driven on the falling
// edge; the expected grant/result of each request is pushed to a scoreboard
// and popped when the DUT pulses done.
// With AND3_ARB_CNT_EN defined the counter is expected to count modulo 2^CNT_W,
// otherwise it is expected to stay 0.
module tb_and3_rr_arbiter;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [2:0]       req;
  logic [2:0]       opnd0, opnd1, opnd2;
  logic [2:0]       gnt, done;
  logic             o, busy;
  logic [CNT_W-1:0] eval_cnt;

  and3_rr_arbiter #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .opnd0    (opnd0),
    .opnd1    (opnd1),
    .opnd2    (opnd2),
    .gnt      (gnt),
    .done     (done),
    .o        (o),
    .busy     (busy),
    .eval_cnt (eval_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] gnt;
    logic       o;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] m_last   = 2'd2;
  int         cnt_model = 0;
  bit         spacing_on = 1'b0;
  int         last_done  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference arbitration: first requester in order last+1, last+2, last.
  function automatic logic [1:0] model_win(input logic [1:0] last, input logic [2:0] r);
    int l;
    l = (last == 2'd3) ? 2 : int'(last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(l + k) % 3]) return 2'((l + k) % 3);
    end
    return 2'(l);
  endfunction

  // One operation: drive request at the IDLE cycle, then follow it through
  // GRANT (where operands may change and req may drop) to the next IDLE.
  task automatic run_op(input logic [2:0] r, input logic [2:0] a0, input logic [2:0] a1,
                        input logic [2:0] a2, input logic [2:0] late, input bit drop);
    logic [1:0] w;
    logic [2:0] sel;
    exp_t       e;
    req   = r;
    opnd0 = a0;
    opnd1 = a1;
    opnd2 = a2;
    w      = model_win(m_last, r);
    m_last = w;
    sel    = (w == 2'd0) ? a0 : (w == 2'd1) ? a1 : a2;
    e.gnt  = 3'b001 << w;
    e.o    = &sel;
    sb.push_back(e);
    @(negedge clk);                       // GRANT cycle
    check("gnt", 32'(gnt), 32'(e.gnt));
    check("busy_grant", 32'(busy), 32'd1);
    opnd0 = late;
    opnd1 = late;
    opnd2 = late;
    if (drop) req = 3'b000;
    @(negedge clk);                       // RESULT cycle, monitor pops
    @(negedge clk);                       // back in IDLE
    check("busy_idle", 32'(busy), 32'd0);
    check("o_hold", 32'(o), 32'(e.o));
  endtask

  // Scoreboard monitor: compares every done pulse with the oldest expectation.
  initial begin
    int   cyc;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done != 3'b000) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done", 32'(done), 32'(e.gnt));
          check("o", 32'(o), 32'(e.o));
`ifdef AND3_ARB_CNT_EN
          check("eval_cnt", 32'(eval_cnt), 32'(cnt_model));
          cnt_model = (cnt_model + 1) % (1 << CNT_W);
`else
          check("eval_cnt", 32'(eval_cnt), 32'd0);
`endif
          if (spacing_on && last_done >= 0) check("done_spacing", 32'(cyc - last_done), 32'd3);
          last_done = cyc;
        end
      end
    end
  end

  initial begin
    logic [1:0] w;
    rst   = 1'b1;
    req   = 3'b111;
    opnd0 = 3'b000;
    opnd1 = 3'b000;
    opnd2 = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_o", 32'(o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(eval_cnt), 32'd0);
    rst = 1'b0;

    // First grant after reset goes to requester 0.
    run_op(3'b111, 3'b111, 3'b000, 3'b000, 3'b111, 1'b0);
    // Single requester 1 with all-ones operands.
    run_op(3'b010, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);

    // All requests held: round-robin rotation with 3-cycle done spacing.
    spacing_on = 1'b1;
    last_done  = -1;
    for (int i = 0; i < 4; i++) run_op(3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 1'b0);
    spacing_on = 1'b0;

    // Operand capture: later changes are ignored; req drop is ignored.
    run_op(3'b001, 3'b111, 3'b000, 3'b000, 3'b011, 1'b0);
    run_op(3'b001, 3'b110, 3'b000, 3'b000, 3'b111, 1'b1);
    run_op(3'b101, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0);
    req = 3'b000;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Reset during GRANT drops the operation and restores the pointer.
    req   = 3'b110;
    opnd1 = 3'b111;
    opnd2 = 3'b111;
    w     = model_win(m_last, 3'b110);
    @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 32'(3'b001 << w));
    rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_o", 32'(o), 32'd0);
    check("mid_rst_cnt", 32'(eval_cnt), 32'd0);
    rst       = 1'b0;
    m_last    = 2'd2;
    cnt_model = 0;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    run_op(3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 1'b0);
    run_op(3'b011, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);

    req = 3'b000;
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
`ifdef AND3_ARB_CNT_EN
    check("final_cnt", 32'(eval_cnt), 32'(cnt_model));
`else
    check("final_cnt", 32'(eval_cnt), 32'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
